// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller for a single-issue ARM-style ALU. It accepts one operation,
// drives an external combinational ALU for exactly one cycle and evaluates the
// condition code. It updates the NZCV flag register and hands the result to the
// register file over a valid/ready write-back port.
//
// Configuration macro:
//   ALU_COND_EXEC_EN  defined   -> issue_cond is evaluated against nzcv;
//                                  failing ops pulse 'skipped'.
//                     undefined -> issue_cond is ignored, every op runs as AL,
//                                  and 'skipped' is tied low.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   issue_valid/ready     issue handshake (ready only while IDLE)
//   issue_opcode/cond/s   ARM data-processing opcode, condition, S bit
//   issue_rd              destination register index (RD_W bits)
//   issue_op_a/op_b       operands; issue_shift_c = shifter carry-out
//   alu_a/b/control/cin   to the external ALU; zero outside EXEC
//   alu_result/alu_nzcv   from the external ALU (same cycle)
//   wb_valid/ready        register-file write handshake; wb_rd, wb_data payload
//   nzcv                  flag register {N,Z,C,V}
//   flush                 one-cycle pulse after a write-back to R15
//   skipped               one-cycle pulse after an op whose condition failed
//   busy                  high in EXEC and WB
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int RD_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [3:0]      issue_opcode,
   input  logic [3:0]      issue_cond,
   input  logic            issue_s,
   input  logic [RD_W-1:0] issue_rd,
   input  logic [31:0]     issue_op_a,
   input  logic [31:0]     issue_op_b,
   input  logic            issue_shift_c,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [3:0]      alu_control,
   output logic            alu_cin,
   input  logic [31:0]     alu_result,
   input  logic [3:0]      alu_nzcv,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic [3:0]      nzcv,
   output logic            flush,
   output logic            skipped,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t          state_reg, state_next;

   logic [3:0]      opcode_reg;
   logic            s_reg;
   logic [RD_W-1:0] rd_reg;
   logic [31:0]     op_a_reg;
   logic [31:0]     op_b_reg;
   logic            shift_c_reg;
   logic [3:0]      nzcv_reg;
   logic [RD_W-1:0] wb_rd_reg;
   logic [31:0]     wb_data_reg;
   logic            flush_reg;

   logic            cond_pass;
   logic            is_test;
   logic            is_logic;
   logic            flag_update;
   logic [3:0]      nzcv_next;

   // TST/TEQ/CMP/CMN (8..11) only set flags; they never write back.
   assign is_test  = (opcode_reg[3:2] == 2'b10);
   // Logical ops take C from the shifter and leave V alone.
   assign is_logic = (opcode_reg[3:1] == 3'b000) ||
                     (opcode_reg[3:1] == 3'b100) ||
                     (opcode_reg[3:2] == 2'b11);
   assign flag_update = s_reg || is_test;
   assign nzcv_next   = is_logic ? {alu_nzcv[3], alu_nzcv[2], shift_c_reg, nzcv_reg[0]}
                                 : alu_nzcv;

`ifdef ALU_COND_EXEC_EN
   logic [3:0] cond_reg;
   logic       skipped_reg;

   always_comb begin
      logic n, z, c, v;
      n = nzcv_reg[3];
      z = nzcv_reg[2];
      c = nzcv_reg[1];
      v = nzcv_reg[0];
      cond_pass = 1'b0;
      case (cond_reg)
         4'd0:    cond_pass = z;
         4'd1:    cond_pass = !z;
         4'd2:    cond_pass = c;
         4'd3:    cond_pass = !c;
         4'd4:    cond_pass = n;
         4'd5:    cond_pass = !n;
         4'd6:    cond_pass = v;
         4'd7:    cond_pass = !v;
         4'd8:    cond_pass = c && !z;
         4'd9:    cond_pass = !c || z;
         4'd10:   cond_pass = (n == v);
         4'd11:   cond_pass = (n != v);
         4'd12:   cond_pass = !z && (n == v);
         4'd13:   cond_pass = z || (n != v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cond_reg    <= 4'd0;
         skipped_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE && issue_valid)
            cond_reg <= issue_cond;
         skipped_reg <= (state_reg == EXEC) && !cond_pass;
      end
   end

   assign skipped = skipped_reg;
`else
   // Condition field has no effect in this build.
   logic unused_cond;
   assign unused_cond = ^issue_cond;
   assign cond_pass   = 1'b1;
   assign skipped     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_next  = state_reg;
      issue_ready = 1'b0;
      busy        = 1'b0;
      wb_valid    = 1'b0;
      alu_a       = 32'd0;
      alu_b       = 32'd0;
      alu_control = 4'd0;
      alu_cin     = 1'b0;
      case (state_reg)
         IDLE: begin
            issue_ready = 1'b1;
            if (issue_valid)
               state_next = EXEC;
         end
         EXEC: begin
            busy        = 1'b1;
            alu_a       = op_a_reg;
            alu_b       = op_b_reg;
            alu_control = opcode_reg;
            alu_cin     = nzcv_reg[1];
            if (!cond_pass || is_test)
               state_next = IDLE;
            else
               state_next = WB;
         end
         WB: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
            if (wb_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, flags and write-back payload
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opcode_reg  <= 4'd0;
         s_reg       <= 1'b0;
         rd_reg      <= '0;
         op_a_reg    <= 32'd0;
         op_b_reg    <= 32'd0;
         shift_c_reg <= 1'b0;
         nzcv_reg    <= 4'd0;
         wb_rd_reg   <= '0;
         wb_data_reg <= 32'd0;
         flush_reg   <= 1'b0;
      end else begin
         if (state_reg == IDLE && issue_valid) begin
            opcode_reg  <= issue_opcode;
            s_reg       <= issue_s;
            rd_reg      <= issue_rd;
            op_a_reg    <= issue_op_a;
            op_b_reg    <= issue_op_b;
            shift_c_reg <= issue_shift_c;
         end
         if (state_reg == EXEC && cond_pass) begin
            if (flag_update)
               nzcv_reg <= nzcv_next;
            if (!is_test) begin
               wb_data_reg <= alu_result;
               wb_rd_reg   <= rd_reg;
            end
         end
         // A completed write to the PC forces a pipeline flush.
         flush_reg <= (state_reg == WB) && wb_ready && (wb_rd_reg == RD_W'(15));
      end
   end

   assign nzcv    = nzcv_reg;
   assign wb_rd   = wb_rd_reg;
   assign wb_data = wb_data_reg;
   assign flush   = flush_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   localparam int RD_W = 4;
`ifdef ALU_COND_EXEC_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            issue_valid = 1'b0;
   logic            issue_ready;
   logic [3:0]      issue_opcode = 4'd0;
   logic [3:0]      issue_cond = 4'd14;
   logic            issue_s = 1'b0;
   logic [RD_W-1:0] issue_rd = '0;
   logic [31:0]     issue_op_a = 32'd0;
   logic [31:0]     issue_op_b = 32'd0;
   logic            issue_shift_c = 1'b0;
   logic [31:0]     alu_a, alu_b;
   logic [3:0]      alu_control;
   logic            alu_cin;
   logic [31:0]     alu_result;
   logic [3:0]      alu_nzcv;
   logic            wb_valid;
   logic            wb_ready = 1'b1;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic [3:0]      nzcv;
   logic            flush, skipped, busy;

   int total = 0;
   int bad   = 0;
   logic [RD_W+31:0] sb[$];

   alu_issue_ctrl #(.RD_W(RD_W)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_opcode(issue_opcode), .issue_cond(issue_cond), .issue_s(issue_s),
      .issue_rd(issue_rd), .issue_op_a(issue_op_a), .issue_op_b(issue_op_b),
      .issue_shift_c(issue_shift_c),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_nzcv(alu_nzcv),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .nzcv(nzcv), .flush(flush), .skipped(skipped), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ARM ALU sitting outside the controller
   logic [31:0] m_x, m_y;
   logic        m_ci, m_arith;
   logic [32:0] m_sum;
   always_comb begin
      m_x = 32'd0; m_y = 32'd0; m_ci = 1'b0; m_arith = 1'b1;
      alu_result = 32'd0;
      case (alu_control)
         4'd2, 4'd10: begin m_x = alu_a; m_y = ~alu_b; m_ci = 1'b1;    end
         4'd3:        begin m_x = alu_b; m_y = ~alu_a; m_ci = 1'b1;    end
         4'd4, 4'd11: begin m_x = alu_a; m_y = alu_b;  m_ci = 1'b0;    end
         4'd5:        begin m_x = alu_a; m_y = alu_b;  m_ci = alu_cin; end
         4'd6:        begin m_x = alu_a; m_y = ~alu_b; m_ci = alu_cin; end
         4'd7:        begin m_x = alu_b; m_y = ~alu_a; m_ci = alu_cin; end
         default:     m_arith = 1'b0;
      endcase
      m_sum = {1'b0, m_x} + {1'b0, m_y} + {32'd0, m_ci};
      case (alu_control)
         4'd0, 4'd8:  alu_result = alu_a & alu_b;
         4'd1, 4'd9:  alu_result = alu_a ^ alu_b;
         4'd12:       alu_result = alu_a | alu_b;
         4'd13:       alu_result = alu_b;
         4'd14:       alu_result = alu_a & ~alu_b;
         4'd15:       alu_result = ~alu_b;
         default:     alu_result = m_sum[31:0];
      endcase
      alu_nzcv = {alu_result[31], alu_result == 32'd0,
                  m_arith & m_sum[32],
                  m_arith & (m_x[31] == m_y[31]) & (m_sum[31] != m_x[31])};
   end

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every write-back handshake must match the oldest push
   always @(negedge clk) begin
      if (reset && wb_valid && wb_ready) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", {35'd0, wb_valid}, 36'd0);
         end else begin
            logic [RD_W+31:0] e;
            e = sb.pop_front();
            chk("wb_rd", {32'd0, wb_rd}, {32'd0, e[RD_W+31:32]});
            chk("wb_data", {4'd0, wb_data}, {4'd0, e[31:0]});
            $display("wb rd=%0d data=%08h", wb_rd, wb_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                           input logic [RD_W-1:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input logic shc);
      int n = 0;
      @(negedge clk);
      while (!issue_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_ready_wait", {35'd0, issue_ready}, 36'd1);
      issue_opcode = op; issue_cond = cond; issue_s = s; issue_rd = rd;
      issue_op_a = a; issue_op_b = b; issue_shift_c = shc; issue_valid = 1'b1;
      @(posedge clk);
      #1 issue_valid = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] cond,
                         input logic s, input logic [RD_W-1:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic shc, input logic exp_cin,
                         input logic exp_wb, input logic [31:0] exp_data,
                         input logic exp_skip, input logic [3:0] exp_nzcv);
      if (exp_wb) sb.push_back({rd, exp_data});
      do_issue(op, cond, s, rd, a, b, shc);
      @(negedge clk);                                  // EXEC cycle
      chk({name, "_exec_busy"}, {35'd0, busy}, 36'd1);
      chk({name, "_exec_ready"}, {35'd0, issue_ready}, 36'd0);
      chk({name, "_alu_a"}, {4'd0, alu_a}, {4'd0, a});
      chk({name, "_alu_b"}, {4'd0, alu_b}, {4'd0, b});
      chk({name, "_alu_ctl"}, {32'd0, alu_control}, {32'd0, op});
      chk({name, "_alu_cin"}, {35'd0, alu_cin}, {35'd0, exp_cin});
      @(negedge clk);                                  // two cycles after accept
      chk({name, "_wb_valid"}, {35'd0, wb_valid}, {35'd0, exp_wb});
      chk({name, "_skipped"}, {35'd0, skipped}, {35'd0, exp_skip});
      chk({name, "_nzcv"}, {32'd0, nzcv}, {32'd0, exp_nzcv});
      if (!exp_wb) begin
         chk({name, "_idle_after_exec"}, {35'd0, issue_ready}, 36'd1);
         chk({name, "_alu_zero"}, {4'd0, alu_a}, 36'd0);
      end
      @(negedge clk);
      chk({name, "_ready_end"}, {35'd0, issue_ready}, 36'd1);
      chk({name, "_skip_end"}, {35'd0, skipped}, 36'd0);
      chk({name, "_flush"}, {35'd0, flush}, {35'd0, exp_wb && rd == 4'd15});
      $display("op %s opcode=%0d cond=%0d nzcv=%04b skipped_seen=%0d", name, op, cond, nzcv, exp_skip);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_wb_valid", {35'd0, wb_valid}, 36'd0);
      chk("rst_nzcv", {32'd0, nzcv}, 36'd0);
      chk("rst_busy", {35'd0, busy}, 36'd0);
      chk("rst_flush", {35'd0, flush}, 36'd0);
      chk("rst_skipped", {35'd0, skipped}, 36'd0);
      chk("rst_wb_data", {4'd0, wb_data}, 36'd0);
      chk("rst_alu_a", {4'd0, alu_a}, 36'd0);
      @(negedge clk);
      reset = 1'b1;

      //          name    op  cond s  rd  a             b             shc cin wb       data          skip     nzcv
      run_op("add",   4,  14, 1, 2,  32'd5,        32'd7,        0,  0,  1,       32'd12,       0,       4'b0000);
      run_op("cmp",   10, 14, 0, 0,  32'd3,        32'd3,        0,  0,  0,       32'd0,        0,       4'b0110);
      run_op("mov_ne",13, 1,  0, 3,  32'd0,        32'd9,        0,  1,  !COND_EN, 32'd9,       COND_EN, 4'b0110);
      run_op("mov_eq",13, 0,  0, 4,  32'd0,        32'd9,        0,  1,  1,       32'd9,        0,       4'b0110);
      run_op("subs",  2,  14, 1, 5,  32'd1,        32'd2,        0,  1,  1,       32'hFFFFFFFF, 0,       4'b1000);
      run_op("mov_lt",13, 11, 0, 6,  32'd0,        32'h55,       0,  0,  1,       32'h55,       0,       4'b1000);
      run_op("mov_ge",13, 10, 0, 7,  32'd0,        32'h66,       0,  0,  !COND_EN, 32'h66,      COND_EN, 4'b1000);
      run_op("movs",  13, 14, 1, 8,  32'd0,        32'd0,        1,  0,  1,       32'd0,        0,       4'b0110);
      run_op("adds_v",4,  14, 1, 9,  32'h7FFFFFFF, 32'd1,        0,  1,  1,       32'h80000000, 0,       4'b1001);
      run_op("ands",  0,  14, 1, 10, 32'hF0,       32'h0F,       0,  0,  1,       32'd0,        0,       4'b0101);
      run_op("tst",   8,  14, 0, 0,  32'h80000000, 32'h80000000, 1,  0,  0,       32'd0,        0,       4'b1011);

      // Write-back back-pressure: payload holds, new issues ignored
      @(posedge clk); #1 wb_ready = 1'b0;
      sb.push_back({4'd11, 32'd2});
      do_issue(4'd4, 4'd14, 1'b0, 4'd11, 32'd1, 32'd1, 1'b0);
      @(negedge clk);
      chk("bp_cin", {35'd0, alu_cin}, 36'd1);
      @(negedge clk);
      chk("bp_latency", {35'd0, wb_valid}, 36'd1);
      issue_opcode = 4'd13; issue_op_b = 32'hDEAD; issue_rd = 4'd1; issue_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {35'd0, wb_valid}, 36'd1);
         chk("bp_data", {4'd0, wb_data}, 36'd2);
         chk("bp_rd", {32'd0, wb_rd}, 36'd11);
         chk("bp_ready", {35'd0, issue_ready}, 36'd0);
      end
      issue_valid = 1'b0;
      @(posedge clk); #1 wb_ready = 1'b1;
      @(negedge clk);                                  // handshake cycle
      @(negedge clk);
      chk("bp_idle", {35'd0, issue_ready}, 36'd1);
      chk("bp_busy", {35'd0, busy}, 36'd0);
      chk("bp_flush", {35'd0, flush}, 36'd0);
      chk("bp_nzcv", {32'd0, nzcv}, 36'b1011);
      @(negedge clk);
      chk("bp_ignored", {35'd0, busy}, 36'd0);
      $display("op backpressure done");

      // Write to R15 -> single flush pulse
      run_op("mov_pc",13, 14, 0, 15, 32'd0, 32'h100, 0, 1, 1, 32'h100, 0, 4'b1011);
      @(negedge clk);
      chk("flush_once", {35'd0, flush}, 36'd0);

      // Reset during WB drops the op
      @(posedge clk); #1 wb_ready = 1'b0;
      do_issue(4'd4, 4'd14, 1'b1, 4'd12, 32'd2, 32'd3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rwb_in_wb", {35'd0, wb_valid}, 36'd1);
      #1 reset = 1'b0;
      #1;
      chk("rwb_valid", {35'd0, wb_valid}, 36'd0);
      chk("rwb_nzcv", {32'd0, nzcv}, 36'd0);
      chk("rwb_busy", {35'd0, busy}, 36'd0);
      chk("rwb_data", {4'd0, wb_data}, 36'd0);
      chk("rwb_rd", {32'd0, wb_rd}, 36'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 wb_ready = 1'b1;
      @(negedge clk);
      chk("rwb_ready", {35'd0, issue_ready}, 36'd1);
      chk("rwb_no_wb", {35'd0, wb_valid}, 36'd0);
      $display("op reset-in-wb done");

      run_op("post_rst",4, 14, 1, 1, 32'd1, 32'd2, 0, 0, 1, 32'd3, 0, 4'b0000);
      repeat (3) @(negedge clk);
      chk("sb_empty", 36'(sb.size()), 36'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter: RD_W, 4, destination register index width.
REQ-002 The block SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports: issue_valid in 1, issue_ready out 1; issue handshake.
REQ-005 The block SHALL have ports: issue_opcode in 4, issue_cond in 4, issue_s in 1, issue_rd in RD_W, issue_op_a in 32, issue_op_b in 32, issue_shift_c in 1 (shifter carry-out).
REQ-006 The block SHALL have ports: alu_a out 32, alu_b out 32, alu_control out 4, alu_cin out 1; alu_result in 32, alu_nzcv in 4 (combinational ALU, same cycle).
REQ-007 The block SHALL have ports: wb_valid out 1, wb_ready in 1, wb_rd out RD_W, wb_data out 32; register-file write handshake.
REQ-008 The block SHALL have ports: nzcv out 4 ({N,Z,C,V} flag register), flush out 1 (R15 written), skipped out 1 (condition failed), busy out 1.

Function
REQ-009 FSM states SHALL be IDLE, EXEC, WB; issue_ready=1 only in IDLE; busy=1 in EXEC and WB.
REQ-010 IDLE: on issue_valid&issue_ready, latch all issue_* fields; next state EXEC.
REQ-011 EXEC (exactly one cycle): alu_a/alu_b/alu_control driven from latched fields, alu_cin=nzcv[1]; outside EXEC alu_* outputs SHALL be 0.
REQ-012 Condition evaluated in EXEC against current nzcv: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 never.
REQ-013 Condition fail: skipped pulses 1 cycle (the cycle after EXEC), no flag update, no write-back, next state IDLE.
REQ-014 Condition pass: flags update at end of EXEC if issue_s=1 or opcode 8..11 (TST/TEQ/CMP/CMN).
REQ-015 Flag update, logical ops (0,1,8,9,12,13,14,15): N,Z from alu_nzcv, C from latched shift_c, V unchanged; arithmetic ops (2..7,10,11): all four from alu_nzcv.
REQ-016 Condition pass, opcode 8..11: no write-back, next state IDLE; otherwise register alu_result into wb_data, latched rd into wb_rd, next state WB.
REQ-017 WB: wb_valid=1, wb_data/wb_rd stable until wb_ready=1; handshake cycle returns to IDLE.
REQ-018 flush SHALL pulse 1 cycle, the cycle after a WB handshake with wb_rd=15; never otherwise.
REQ-019 Minimum latency accept->wb_valid: 2 cycles; max throughput one op per 3 cycles; issue_valid outside IDLE ignored.
REQ-020 Flags updated in EXEC SHALL be visible to the condition check of the next accepted op.

Reset
REQ-021 reset=0 SHALL asynchronously force state IDLE, nzcv=0, wb_valid=0, wb_data=0, wb_rd=0, flush=0, skipped=0, busy=0, alu_*=0.
REQ-022 Reset mid-operation SHALL discard the op without write-back or flag update; issue_ready=1 first cycle after release.

Configuration
REQ-023 Macro ALU_COND_EXEC_EN defined: REQ-012/013 apply.
REQ-024 ALU_COND_EXEC_EN undefined: issue_cond ignored, every op executes as AL, skipped tied 0.

Verification
REQ-025 After reset, ADD(4) a=5 b=7 s=1 rd=2 cond=14, wb_ready=1 -> wb_valid 2 cycles after accept, wb_data=12, wb_rd=2, nzcv=0000.
REQ-026 CMP(10) a=3 b=3 cond=14 -> no wb_valid, nzcv=0110, back to IDLE after EXEC.
REQ-027 After REQ-026, MOV(13) b=9 cond=1(NE) -> skipped pulse, no wb, nzcv=0110; same with cond=0(EQ) -> wb_data=9.
REQ-028 ADD with wb_ready=0 for 5 cycles -> wb_valid, wb_data, wb_rd stable, issue_ready=0; wb_ready=1 -> handshake, IDLE next cycle.
REQ-029 MOV(13) b=0x100 rd=15 cond=14 -> wb_data=0x100, flush=1 exactly one cycle after handshake.
REQ-030 reset=0 during WB -> wb_valid=0 immediately, nzcv=0; after release issue_ready=1, no write-back of dropped op.
